// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one up-counter among NREQ
// requesters. Each grant loads the counter with the winner's start value and
// waits for the counter output to reach the winner's target.
//
// Optional feature macro: CNT_SCHED_TIMEOUT_EN
//   defined   -> RUN watchdog; after 2^WIDTH RUN cycles without a match the
//                transaction ends with done and err together.
//   undefined -> RUN waits indefinitely; err only flags misaligned requests.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; samples req and latches the round-robin winner
// LOAD   | grant pulse; counter loaded with the winner's start value
// ERR    | grant pulse with err; (target - start) not a multiple of INCR
// RUN    | watching cnt_out until it equals the latched target
// DONE   | done pulse to the winner (plus err on watchdog expiry)
module counter_sched #(
  parameter int WIDTH = 4,
  parameter int INCR  = 2,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] start_flat,
  input  logic [NREQ*WIDTH-1:0] target_flat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic                  load,
  output logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH-1:0]      cnt_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Low bits of the distance that must be zero for the counter to land on
  // the target; an all-zero mask when INCR == 1 disables the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INCR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ERR,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] target_q;

  logic [PW-1:0]    pick;
  logic             pick_vld;
  logic [WIDTH-1:0] pick_start;
  logic [WIDTH-1:0] pick_target;
  logic [WIDTH-1:0] pick_dist;
  logic             pick_aligned;
  logic             hit;

`ifdef CNT_SCHED_TIMEOUT_EN
  localparam logic [WIDTH:0] WD_LAST = {1'b0, {WIDTH{1'b1}}};
  logic [WIDTH:0] wd;
  logic           tmo_q;
  logic           wd_expire;
`endif

  assign hit = (cnt_out == target_q);

`ifdef CNT_SCHED_TIMEOUT_EN
  assign wd_expire = (wd == WD_LAST);
`endif

  // Round-robin pick: first asserted req at or after the pointer.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = PW'(idx);
      end
    end
    pick_start   = start_flat[int'(pick)*WIDTH +: WIDTH];
    pick_target  = target_flat[int'(pick)*WIDTH +: WIDTH];
    pick_dist    = pick_target - pick_start;
    pick_aligned = ((pick_dist & ALIGN_MASK) == '0);
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_vld) state_nxt = pick_aligned ? S_LOAD : S_ERR;
      end
      S_LOAD: state_nxt = S_RUN;
      S_ERR:  state_nxt = S_IDLE;
      S_RUN: begin
        if (hit) state_nxt = S_DONE;
`ifdef CNT_SCHED_TIMEOUT_EN
        else if (wd_expire) state_nxt = S_DONE;
`endif
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, winner latch and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      win      <= '0;
      start_q  <= '0;
      target_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_vld) begin
        win      <= pick;
        start_q  <= pick_start;
        target_q <= pick_target;
      end
      if (state == S_LOAD || state == S_ERR) begin
        ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef CNT_SCHED_TIMEOUT_EN
  // RUN watchdog; held at zero outside RUN so every RUN entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd    <= (state == S_RUN) ? wd + 1'b1 : '0;
      tmo_q <= (state == S_RUN) && !hit && wd_expire;
    end
  end
`endif

  // Outputs decode only state and latched registers.
  always_comb begin
    gnt     = '0;
    done    = '0;
    err     = 1'b0;
    load    = 1'b0;
    data_in = '0;
    busy    = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        gnt[win] = 1'b1;
        load     = 1'b1;
        data_in  = start_q;
      end
      S_ERR: begin
        gnt[win] = 1'b1;
        err      = 1'b1;
      end
      S_DONE: begin
        done[win] = 1'b1;
`ifdef CNT_SCHED_TIMEOUT_EN
        err       = tmo_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched (WIDTH=4, INCR=2, NREQ=2) with a
// behavioural counter attached. Timeout steps are built only when
// CNT_SCHED_TIMEOUT_EN is defined.
module tb_counter_sched;

  localparam int WIDTH = 4;
  localparam int INCR  = 2;
  localparam int NREQ  = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] start_flat;
  logic [NREQ*WIDTH-1:0] target_flat;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  busy;
  logic                  load;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      cnt_out;

  logic [WIDTH-1:0]      cnt_q;
  logic                  stuck;

  int checks = 0;
  int errors = 0;

  counter_sched #(.WIDTH(WIDTH), .INCR(INCR), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .start_flat  (start_flat),
    .target_flat (target_flat),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .load        (load),
    .data_in     (data_in),
    .cnt_out     (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: load takes priority, otherwise steps by INCR.
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (load) cnt_q <= data_in;
    else           cnt_q <= cnt_q + WIDTH'(INCR);
  end

  assign cnt_out = stuck ? '0 : cnt_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    start_flat[r*WIDTH +: WIDTH]  = s;
    target_flat[r*WIDTH +: WIDTH] = t;
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] exp_g;
    rst         = 1'b1;
    req         = 2'b11;
    stuck       = 1'b0;
    start_flat  = '0;
    target_flat = '0;
    set_req(0, 4'd2, 4'd2);
    set_req(1, 4'd4, 4'd4);

    // Reset held with both requests up.
    tick(); tick(); tick();
    check("rst_gnt",     32'(gnt),     32'h0);
    check("rst_done",    32'(done),    32'h0);
    check("rst_err",     32'(err),     32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_load",    32'(load),    32'h0);
    check("rst_data_in", 32'(data_in), 32'h0);
    rst = 1'b0;

    // First grant after reset goes to requester 0.
    tick();
    check("rst_first_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick(); tick();
    check("rst_first_done", 32'(done), 32'h1);
    tick();
    check("rst_idle", 32'(busy), 32'h0);

    // Basic: requester 1 would be next, so use requester 1 first? No: pointer is 1.
    // Wrap-around on requester 1: 14 -> 0 -> 2.
    set_req(1, 4'd14, 4'd2);
    req = 2'b10;
    tick();
    check("wrap_gnt",     32'(gnt),     32'h2);
    check("wrap_load",    32'(load),    32'h1);
    check("wrap_data_in", 32'(data_in), 32'd14);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wrap_wait_done", 32'(done), 32'h0);
    end
    tick();
    check("wrap_done", 32'(done), 32'h2);
    check("wrap_err",  32'(err),  32'h0);
    tick();

    // Basic on requester 0: 2, 4, 6, 8.
    set_req(0, 4'd2, 4'd8);
    req = 2'b01;
    tick();
    check("basic_gnt",     32'(gnt),     32'h1);
    check("basic_load",    32'(load),    32'h1);
    check("basic_data_in", 32'(data_in), 32'd2);
    check("basic_err_g",   32'(err),     32'h0);
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("basic_wait_done", 32'(done), 32'h0);
      check("basic_busy",      32'(busy), 32'h1);
      check("basic_no_load",   32'(load), 32'h0);
    end
    tick();
    check("basic_done",  32'(done), 32'h1);
    check("basic_err_d", 32'(err),  32'h0);
    tick();
    check("basic_idle", 32'(busy), 32'h0);

    // Misaligned: dist = 3 on requester 1 (pointer now at 1).
    set_req(1, 4'd1, 4'd4);
    req = 2'b10;
    tick();
    check("mis_gnt",  32'(gnt),  32'h2);
    check("mis_err",  32'(err),  32'h1);
    check("mis_load", 32'(load), 32'h0);
    req = 2'b00;
    tick();
    check("mis_idle", 32'(busy), 32'h0);
    check("mis_done", 32'(done), 32'h0);
    check("mis_gnt2", 32'(gnt),  32'h0);

    // Mid-RUN reset on requester 0 (pointer at 0): no done afterwards.
    set_req(0, 4'd0, 4'd14);
    req = 2'b01;
    tick();
    check("mrst_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_done", 32'(done), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mrst_quiet", 32'({done, gnt, busy}), 32'h0);
    end

    // Fairness: both held; grants must alternate 0,1,0,1 after reset.
    set_req(0, 4'd2, 4'd2);
    set_req(1, 4'd6, 4'd6);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (gnt == '0 && n < 10) begin
        tick();
        n++;
      end
      check("fair_gnt", 32'(gnt), 32'(exp_g));
      n = 0;
      tick();
      while (done == '0 && n < 10) begin
        check("fair_single", 32'(gnt), 32'h0);
        tick();
        n++;
      end
      check("fair_done", 32'(done), 32'(exp_g));
    end
    req = 2'b00;
    tick(); tick();

`ifdef CNT_SCHED_TIMEOUT_EN
    // Watchdog: counter stuck at 0, target 8 never reached.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stuck = 1'b1;
    set_req(0, 4'd2, 4'd8);
    req = 2'b01;
    tick();
    check("tmo_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("tmo_wait", 32'({done, err}), 32'h0);
    end
    tick();
    check("tmo_done", 32'(done), 32'h1);
    check("tmo_err",  32'(err),  32'h1);
    tick();
    check("tmo_idle", 32'(busy), 32'h0);
    stuck = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the directed sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one `counter` instance (parameters WIDTH, INCR; ports `load`, `data_in`, `out`) among NREQ requesters. Each requester posts a start value and a target value. The scheduler loads the counter with the start value, watches its output until it equals the target, then signals completion to that requester. It sits between requester logic and the counter, and it alone drives the counter's `load` and `data_in`.

## Interface
- WIDTH, 4, counter width; must match the counter's WIDTH.
- INCR, 2, counter step; must match the counter's INCR; must be a power of two.
- NREQ, 2, number of requesters (2..8).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- start_flat  in  NREQ*WIDTH  start value; requester i uses bits [i*WIDTH +: WIDTH].
- target_flat  in  NREQ*WIDTH  target value, same packing as start_flat.
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted.
- done  out  NREQ  one-hot, one-cycle pulse: request finished.
- err  out  1  one-cycle pulse, qualified by gnt (misaligned request) or by done (timeout).
- busy  out  1  high in every state except IDLE.
- load  out  1  to counter `load`.
- data_in  out  WIDTH  to counter `data_in`.
- cnt_out  in  WIDTH  from counter `out`.

## Operation
- States: IDLE, LOAD, ERR, RUN, DONE.
- IDLE
  - At a clock edge with any req bit high, pick the winner round-robin from the priority pointer.
  - Latch the winner's start and target values.
  - Compute dist = (target − start) mod 2^WIDTH.
  - If dist[$clog2(INCR)-1:0] == 0, go to LOAD; otherwise go to ERR. The check is skipped when INCR = 1.
- LOAD (1 cycle)
  - gnt[w] = 1, load = 1, data_in = start.
  - Go to RUN.
- ERR (1 cycle)
  - gnt[w] = 1, err = 1, load = 0.
  - Go to IDLE.
- RUN
  - At each edge, if cnt_out == target, go to DONE; otherwise stay in RUN.
  - Wrap-around is native: cnt_out wraps modulo 2^WIDTH.
- DONE (1 cycle)
  - done[w] = 1.
  - Go to IDLE.
- Round-robin pointer
  - Reset value 0.
  - On every grant to w (LOAD or ERR), the pointer becomes (w+1) mod NREQ.
- Request handshake
  - req is sampled only in IDLE.
  - A requester must deassert req no later than the edge that ends its gnt cycle; otherwise it is re-arbitrated as a new request.
  - start_flat and target_flat are only required to be stable at the edge where IDLE samples req.
- Outputs are combinational decodes of state and the latched winner only; there is no combinational path from req to any output.
- Reset
  - Effective at any state, including mid-RUN.
  - Next state is IDLE; the pointer and latched values clear.
  - In-flight requests are dropped with no done pulse.
- Reset values: gnt = 0, done = 0, err = 0, busy = 0, load = 0, data_in = 0.

## Timing
- Edge e samples req in IDLE; cycle e+1 is LOAD (gnt and load high); the counter shows start in cycle e+2 (first RUN cycle).
- When cnt_out == target in RUN cycle k, done is high in cycle k+1.
- Best case, target == start: done is high 3 cycles after the sampling edge.
- ERR path: gnt and err are high in cycle e+1; the earliest next sampling edge is the one ending cycle e+2.
- Simultaneous requests: exactly one is granted per IDLE pass; the others wait.
- No request is accepted while busy = 1.

## Configuration
- CNT_SCHED_TIMEOUT_EN, defined:
  - Adds a WIDTH+1-bit RUN watchdog, cleared on entry to RUN.
  - If RUN lasts 2^WIDTH cycles without a match, go to DONE with done[w] = 1 and err = 1 in the same cycle.
- CNT_SCHED_TIMEOUT_EN, undefined:
  - No watchdog; RUN waits indefinitely; err is asserted only from ERR.

## Test plan
WIDTH = 4, INCR = 2, NREQ = 2; the real counter is attached unless noted.
- Reset: hold rst for 3 cycles with req = 2'b11 → all outputs 0, busy = 0; after release, the first grant goes to requester 0.
- Basic: req[0], start = 2, target = 8 → gnt[0] and load with data_in = 2 in cycle e+1; cnt_out 2, 4, 6, 8; done[0] in the cycle after 8; err stays 0.
- Wrap-around: req[1], start = 14, target = 2 → cnt_out 14, 0, 2 → done[1]; no err.
- Misaligned: req[0], start = 1, target = 4 → gnt[0] + err in cycle e+1; load never asserts; done stays 0; back in IDLE.
- Fairness: req = 2'b11 held, each requester re-requesting after its done → grant order 0, 1, 0, 1; one transaction in flight at a time.
- With CNT_SCHED_TIMEOUT_EN: the bench drives cnt_out stuck at 0, start = 2, target = 8 → after 16 RUN cycles, done[0] + err in the same cycle; a mid-RUN rst instead → IDLE next cycle, no done.
